ahb2apb_bridge: RTL
===================

# ahb2apb_bridge

Single-clock AHB-Lite slave to APB (AMBA 2, no PREADY) master bridge for the AHB subsystem. It accepts one AHB transfer at a time and inserts wait states while it runs an APB SETUP/ENABLE sequence. It decodes the address into a one-hot 16-bit PSEL and returns read data taken from the PRDATA input. PRDATA comes from the APB read-data mux, which returns 0 unless PSEL is one-hot.

## Interface
Parameters:
- SEL_LSB, 12, LSB of the 4-bit slave index field in HADDR; index = HADDR[SEL_LSB+3:SEL_LSB]

Ports:
- PCLK  input  1  clock; the AHB and APB sides share this single clock
- PRST_N  input  1  reset, asynchronous, active-low
- HSEL  input  1  bridge selected by the AHB decoder
- HTRANS  input  2  AHB transfer type; NONSEQ and SEQ (HTRANS[1]=1) are valid
- HWRITE  input  1  1 = write
- HADDR  input  32  transfer address
- HWDATA  input  32  write data, valid in the data phase
- HREADY  input  1  bus-level ready; qualifies the address phase
- HREADYOUT  output  1  bridge ready, 0 = wait state
- HRESP  output  2  always 2'b00 (OKAY)
- HRDATA  output  32  registered read data
- PSEL  output  16  one-hot APB slave select
- PENABLE  output  1  APB enable phase
- PWRITE  output  1  APB direction
- PADDR  output  32  APB address, the full latched HADDR
- PWDATA  output  32  APB write data
- PRDATA  input  32  muxed APB read data

## Operation
- Accept condition: HSEL & HTRANS[1] & HREADY, sampled on the PCLK rising edge in state IDLE or DONE.
  - On accept, latch HADDR into PADDR and HWRITE into PWRITE.
  - Latch a slave index into an internal register.
  - Transfers that fail the accept condition (IDLE/BUSY, HSEL=0, HREADY=0) are ignored with no state change.
- States:
  - IDLE: HREADYOUT=1. On accept, a read goes to SETUP and a write goes to WDATA. Otherwise stay in IDLE.
  - WDATA: HREADYOUT=0, PSEL=0. Capture HWDATA into PWDATA. Go to SETUP.
  - SETUP: HREADYOUT=0, PSEL=onehot(index), PENABLE=0. Go to ENABLE.
  - ENABLE: HREADYOUT=0, PSEL held, PENABLE=1. For a read, register PRDATA into HRDATA at the end of the cycle. Go to DONE.
  - DONE: HREADYOUT=1, PSEL=0, PENABLE=0. This is the data-phase completion cycle.
    - On accept, a read goes to SETUP and a write goes to WDATA.
    - Otherwise go to IDLE.
- PADDR, PWRITE and PWDATA stay stable from SETUP through ENABLE. They are held afterwards until the next accept or WDATA capture.
- HRDATA holds its value until the next read's ENABLE cycle; writes do not alter it.
- HRESP is always OKAY. There is no error path and no PSLVERR.
- PSEL is always one-hot or zero; it is never multi-hot.
- Index wraps naturally: only 4 bits are used, and higher address bits are passed to PADDR only.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0; state=IDLE.
- Read, with the address phase at cycle 0:
  - cycles 1 and 2 are SETUP and ENABLE with HREADYOUT=0;
  - cycle 3 is DONE with HREADYOUT=1 and HRDATA valid;
  - this gives 2 wait states.
- Write, with the address phase at cycle 0:
  - cycle 1 is WDATA;
  - cycles 2 and 3 are SETUP and ENABLE;
  - cycle 4 is DONE with HREADYOUT=1;
  - this gives 3 wait states.
- Back-to-back: the address phase of the next transfer coincides with DONE, so the next SETUP or WDATA immediately follows. PSEL therefore has a gap of at least one cycle between transfers.
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronous) and the state goes to IDLE. No APB cycle is completed.
- PENABLE is asserted only in ENABLE and is never high without PSEL.

## Test plan
- Reset behaviour: assert PRST_N=0 during ENABLE of a read. Outputs go to their reset values and the state goes to IDLE. After release, an idle bus keeps HREADYOUT=1 and PSEL=0.
- Single read: read of HADDR=0x0000_3004 with PRDATA=0xDEAD_BEEF in ENABLE.
  - PSEL=16'h0008 and PADDR=0x3004 in cycles 1-2; PENABLE=1 only in cycle 2.
  - Cycle 3 shows HREADYOUT=1 and HRDATA=0xDEAD_BEEF.
- Single write: write of HADDR=0x0000_F010 with HWDATA=0x1234_5678.
  - PSEL=16'h8000, PWRITE=1 and PWDATA=0x1234_5678 in cycles 2-3.
  - HREADYOUT goes low for cycles 1-3, and HRDATA is unchanged.
- Back-to-back: a write to slave 1 whose DONE accepts a read from slave 2.
  - PSEL=16'h0002, then 0 for one cycle, then 16'h0004.
  - No cycle has both PSEL bits set.
- Ignored transfers:
  - HTRANS=IDLE, HSEL=0, and HREADY=0 with HTRANS=NONSEQ each produce no PSEL activity and keep HREADYOUT=1.
  - HRESP stays 2'b00 throughout.
- Index decode sweep: reads with HADDR[15:12]=0..15. Each produces exactly PSEL=1<<index. HADDR=0xABCD_5000 gives PSEL=16'h0020 and PADDR=0xABCD_5000.

Source files
------------

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge, single clock.
// One transfer at a time; wait states cover the APB SETUP/ENABLE phases.
module ahb2apb_bridge #(
  parameter int SEL_LSB = 12
) (
  input  logic        PCLK,
  input  logic        PRST_N,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_SETUP,
    S_ENABLE,
    S_DONE
  } state_t;

  state_t      r_state;
  logic        r_hreadyout;
  logic [31:0] r_hrdata;
  logic [15:0] r_psel;
  logic        r_penable;
  logic        r_pwrite;
  logic [31:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_idx;

  logic        w_accept;
  logic [3:0]  w_haddr_idx;
  logic [15:0] w_sel_haddr;
  logic [15:0] w_sel_idx;

  assign w_accept    = HSEL & HTRANS[1] & HREADY;
  assign w_haddr_idx = HADDR[SEL_LSB+3:SEL_LSB];
  assign w_sel_haddr = 16'(1) << w_haddr_idx;
  assign w_sel_idx   = 16'(1) << r_idx;

  // Transfer sequencer with all bus outputs registered.
  always_ff @(posedge PCLK or negedge PRST_N) begin
    if (!PRST_N) begin
      r_state     <= S_IDLE;
      r_hreadyout <= 1'b1;
      r_hrdata    <= '0;
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_idx       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          r_psel    <= '0;
          r_penable <= 1'b0;
          if (w_accept) begin
            r_paddr     <= HADDR;
            r_pwrite    <= HWRITE;
            r_idx       <= w_haddr_idx;
            r_hreadyout <= 1'b0;
            if (HWRITE) begin
              r_state <= S_WDATA;
            end else begin
              r_state <= S_SETUP;
              r_psel  <= w_sel_haddr;
            end
          end else begin
            r_state     <= S_IDLE;
            r_hreadyout <= 1'b1;
          end
        end
        S_WDATA: begin
          r_pwdata <= HWDATA;
          r_psel   <= w_sel_idx;
          r_state  <= S_SETUP;
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ENABLE;
        end
        S_ENABLE: begin
          if (!r_pwrite) r_hrdata <= PRDATA;
          r_psel      <= '0;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b1;
          r_state     <= S_DONE;
        end
        default: begin
          r_state     <= S_IDLE;
          r_psel      <= '0;
          r_penable   <= 1'b0;
          r_hreadyout <= 1'b1;
        end
      endcase
    end
  end

  assign HREADYOUT = r_hreadyout;
  assign HRESP     = 2'b00;
  assign HRDATA    = r_hrdata;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;

endmodule
